// File: rtl/regfile_mp.sv
// DEPTH x WIDTH register file: two prioritised write ports (D over E), two combinational read ports.
// Writes land on the enable edge and reads have 0 latency; all writes are ignored until the post-reset clear sweep raises ready.
module regfile_mp #(
   parameter int WIDTH    = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              D_En,
   input  logic [ADDR_W-1:0] D_Addr,
   input  logic [WIDTH-1:0]  D_in,
   input  logic              E_En,
   input  logic [ADDR_W-1:0] E_Addr,
   input  logic [WIDTH-1:0]  E_in,
   input  logic [ADDR_W-1:0] S_Addr,
   input  logic [ADDR_W-1:0] T_Addr,
   output logic [WIDTH-1:0]  S,
   output logic [WIDTH-1:0]  T,
   output logic              ready
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W+1)'(1);

   typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W:0]   clr_idx, clr_idx_nxt;
   logic              ready_nxt;
   logic              d_wr, e_wr;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] rd_addr [2];
   logic [WIDTH-1:0]  rd_dat  [2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= INIT;
         clr_idx <= '0;
         ready   <= 1'b0;
      end else begin
         state   <= state_nxt;
         clr_idx <= clr_idx_nxt;
         ready   <= ready_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      ready_nxt   = ready;
      case (state)
         INIT: begin
            clr_idx_nxt = clr_idx + IDX_ONE;
            if (clr_idx == LAST_IDX) begin
               state_nxt = RUN;
               ready_nxt = 1'b1;
            end
         end
         RUN:     ready_nxt = 1'b1;
         default: state_nxt = INIT;
      endcase
   end

   // Qualified writes: a dropped write neither stores nor forwards.
   always_comb begin
      d_wr = (state == RUN) && D_En && !(ZERO_REG && (D_Addr == '0));
      e_wr = (state == RUN) && E_En && !(ZERO_REG && (E_Addr == '0))
             && !(D_En && (D_Addr == E_Addr));
   end

   always_ff @(posedge clk) begin
      if (state == INIT) begin
         mem[clr_idx[ADDR_W-1:0]] <= '0;
      end else begin
         if (e_wr) mem[E_Addr] <= E_in;
         if (d_wr) mem[D_Addr] <= D_in;
      end
   end

   assign rd_addr[0] = S_Addr;
   assign rd_addr[1] = T_Addr;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_dat[p] = mem[rd_addr[p]];
         if (BYPASS && e_wr && (E_Addr == rd_addr[p])) rd_dat[p] = E_in;
         if (BYPASS && d_wr && (D_Addr == rd_addr[p])) rd_dat[p] = D_in;
         if ((state != RUN) || (ZERO_REG && (rd_addr[p] == '0))) rd_dat[p] = '0;
      end
   end

   assign S = rd_dat[0];
   assign T = rd_dat[1];

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default instance (32x32, zero reg, bypass) and a small one (8x16, no zero reg, no bypass).
module tb_regfile_mp;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic started = 1'b0;
   always #5 clk = ~clk;

   logic        d_en [2];
   logic        e_en [2];
   logic [4:0]  d_addr [2];
   logic [4:0]  e_addr [2];
   logic [4:0]  s_addr [2];
   logic [4:0]  t_addr [2];
   logic [31:0] d_in [2];
   logic [31:0] e_in [2];

   logic [31:0] s0, t0;
   logic [15:0] s1, t1;
   logic        rdy0, rdy1;
   logic [31:0] s_act [2];
   logic [31:0] t_act [2];
   logic        r_act [2];

   int          dep_c [2] = '{32, 8};
   bit          zr_c  [2] = '{1'b1, 1'b0};
   bit          bp_c  [2] = '{1'b1, 1'b0};
   logic [31:0] wmask [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};
   logic [31:0] amask [2] = '{32'd31, 32'd7};

   int          edges [2] = '{0, 0};
   logic [31:0] ref_mem [2][32];
   int          n_chk = 0;
   int          n_pass = 0;

   regfile_mp u_big (
      .clk(clk), .reset(rst),
      .D_En(d_en[0]), .D_Addr(d_addr[0]), .D_in(d_in[0]),
      .E_En(e_en[0]), .E_Addr(e_addr[0]), .E_in(e_in[0]),
      .S_Addr(s_addr[0]), .T_Addr(t_addr[0]),
      .S(s0), .T(t0), .ready(rdy0)
   );

   regfile_mp #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_small (
      .clk(clk), .reset(rst),
      .D_En(d_en[1]), .D_Addr(d_addr[1][2:0]), .D_in(d_in[1][15:0]),
      .E_En(e_en[1]), .E_Addr(e_addr[1][2:0]), .E_in(e_in[1][15:0]),
      .S_Addr(s_addr[1][2:0]), .T_Addr(t_addr[1][2:0]),
      .S(s1), .T(t1), .ready(rdy1)
   );

   assign s_act[0] = s0;
   assign t_act[0] = t0;
   assign r_act[0] = rdy0;
   assign s_act[1] = {16'h0, s1};
   assign t_act[1] = {16'h0, t1};
   assign r_act[1] = rdy1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
   endtask

   // Reference rules: a write is live only once the sweep is done, never to reg 0 with a zero
   // register, and E loses outright when both ports target the same address.
   function automatic bit d_ok(int i);
      return d_en[i] && !(zr_c[i] && d_addr[i] == 5'd0);
   endfunction

   function automatic bit e_ok(int i);
      return e_en[i] && !(zr_c[i] && e_addr[i] == 5'd0) && !(d_en[i] && d_addr[i] == e_addr[i]);
   endfunction

   function automatic logic [31:0] exp_rd(int i, logic [4:0] a);
      if (edges[i] < dep_c[i]) return 32'd0;
      if (zr_c[i] && a == 5'd0) return 32'd0;
      if (bp_c[i] && d_ok(i) && d_addr[i] == a) return d_in[i] & wmask[i];
      if (bp_c[i] && e_ok(i) && e_addr[i] == a) return e_in[i] & wmask[i];
      return ref_mem[i][a];
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         edges[0] = 0;
         edges[1] = 0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (edges[i] < dep_c[i]) begin
               edges[i]++;
               if (edges[i] == dep_c[i])
                  for (int a = 0; a < 32; a++) ref_mem[i][a] = 32'd0;
            end else begin
               if (d_ok(i)) ref_mem[i][d_addr[i]] = d_in[i] & wmask[i];
               if (e_ok(i)) ref_mem[i][e_addr[i]] = e_in[i] & wmask[i];
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < 2; i++) begin
            chk(i == 0 ? "cmp_ready0" : "cmp_ready1", 32'(r_act[i]), 32'(edges[i] >= dep_c[i]));
            chk(i == 0 ? "cmp_s0" : "cmp_s1", s_act[i], exp_rd(i, s_addr[i]));
            chk(i == 0 ? "cmp_t0" : "cmp_t1", t_act[i], exp_rd(i, t_addr[i]));
         end
      end
   end

   function automatic logic [4:0] ra(int i);
      logic [31:0] r;
      r = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : 32'($urandom);
      return 5'(r & amask[i]);
   endfunction

   task automatic clr_inputs();
      for (int i = 0; i < 2; i++) begin
         d_en[i] = 1'b0; e_en[i] = 1'b0;
         d_addr[i] = 5'd0; e_addr[i] = 5'd0; s_addr[i] = 5'd0; t_addr[i] = 5'd0;
         d_in[i] = 32'd0; e_in[i] = 32'd0;
      end
   endtask

   // With allow_wr clear, enables only toggle while an instance is still sweeping.
   task automatic rnd_inputs(input bit allow_wr);
      for (int i = 0; i < 2; i++) begin
         logic rdy_i;
         rdy_i = r_act[i];
         d_en[i] = ($urandom_range(0, 1) == 1) && (allow_wr || !rdy_i);
         e_en[i] = ($urandom_range(0, 1) == 1) && (allow_wr || !rdy_i);
         d_addr[i] = ra(i);
         e_addr[i] = ($urandom_range(0, 3) == 0) ? d_addr[i] : ra(i);
         d_in[i] = $urandom & wmask[i];
         e_in[i] = $urandom & wmask[i];
         s_addr[i] = ($urandom_range(0, 2) == 0) ? d_addr[i] : ra(i);
         t_addr[i] = ($urandom_range(0, 2) == 0) ? e_addr[i] : ra(i);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic measure(input string tag);
      int n0 = 0;
      int n1 = 0;
      for (int n = 1; n <= 40; n++) begin
         cyc();
         if (rdy0 && n0 == 0) n0 = n;
         if (rdy1 && n1 == 0) n1 = n;
         rnd_inputs(1'b0);
      end
      chk({tag, "_rise_big"}, 32'(n0), 32'd32);
      chk({tag, "_rise_small"}, 32'(n1), 32'd8);
   endtask

   task automatic scan_zero(input string tag);
      for (int a = 0; a < 32; a++) begin
         clr_inputs();
         s_addr[0] = 5'(a);
         t_addr[0] = 5'(31 - a);
         s_addr[1] = 5'(a & 7);
         t_addr[1] = 5'(7 - (a & 7));
         #1;
         chk({tag, "_zero_s0"}, s0, 32'd0);
         chk({tag, "_zero_t1"}, t_act[1], 32'd0);
         cyc();
      end
   endtask

   initial begin
      clr_inputs();
      #2 rst = 1'b0;
      started = 1'b1;
      repeat (3) begin cyc(); rnd_inputs(1'b0); end
      chk("rst_ready0", 32'(rdy0), 32'd0);
      chk("rst_ready1", 32'(rdy1), 32'd0);
      chk("rst_s0", s0, 32'd0);
      rst = 1'b1;
      measure("pwr");
      scan_zero("pwr");

      clr_inputs();
      d_en[0] = 1'b1; d_addr[0] = 5'd5; d_in[0] = 32'hDEAD_BEEF; s_addr[0] = 5'd5;
      cyc();
      d_en[0] = 1'b0;
      #1;
      chk("basic_s", s0, 32'hDEAD_BEEF);
      chk("basic_model", exp_rd(0, 5'd5), 32'hDEAD_BEEF);

      d_en[0] = 1'b1; d_addr[0] = 5'd0; d_in[0] = 32'hFFFF_FFFF; s_addr[0] = 5'd0;
      #1;
      chk("zero_bypass", s0, 32'd0);
      cyc();
      d_en[0] = 1'b0;
      #1;
      chk("zero_read", s0, 32'd0);

      d_en[1] = 1'b1; d_addr[1] = 5'd0; d_in[1] = 32'h0000_1234;
      cyc();
      clr_inputs();
      #1;
      chk("small_reg0", t_act[1], 32'h0000_1234);
      chk("small_reg0_model", exp_rd(1, 5'd0), 32'h0000_1234);

      d_en[0] = 1'b1; e_en[0] = 1'b1; d_addr[0] = 5'd9; e_addr[0] = 5'd9;
      d_in[0] = 32'h1111_1111; e_in[0] = 32'h2222_2222;
      cyc();
      clr_inputs();
      s_addr[0] = 5'd9;
      #1;
      chk("conflict", s0, 32'h1111_1111);

      d_en[0] = 1'b1; e_en[0] = 1'b1; d_addr[0] = 5'd3; e_addr[0] = 5'd4;
      d_in[0] = 32'h3333_0003; e_in[0] = 32'h4444_0004;
      cyc();
      clr_inputs();
      s_addr[0] = 5'd3; t_addr[0] = 5'd4;
      #1;
      chk("dual_s", s0, 32'h3333_0003);
      chk("dual_t", t0, 32'h4444_0004);

      d_en[0] = 1'b1; d_addr[0] = 5'd7; d_in[0] = 32'hA5A5_A5A5; t_addr[0] = 5'd7;
      d_en[1] = 1'b1; d_addr[1] = 5'd7; d_in[1] = 32'h0000_0F0F;
      #1;
      chk("bypass_t", t0, 32'hA5A5_A5A5);
      cyc();
      d_en[0] = 1'b0;
      d_in[1] = 32'h0000_A5A5; t_addr[1] = 5'd7;
      #1;
      chk("nobypass_old", t_act[1], 32'h0000_0F0F);
      cyc();
      d_en[1] = 1'b0;
      #1;
      chk("nobypass_new", t_act[1], 32'h0000_A5A5);

      repeat (3000) begin cyc(); rnd_inputs(1'b1); end

      clr_inputs();
      rst = 1'b0;
      repeat (2) cyc();
      rst = 1'b1;
      repeat (10) begin cyc(); rnd_inputs(1'b0); end
      chk("mid_ready_edge10", 32'(rdy0), 32'd0);
      rst = 1'b0;
      repeat (2) begin cyc(); rnd_inputs(1'b0); end
      rst = 1'b1;
      measure("mid");
      scan_zero("mid");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, the next generation of the 32x32 CPU register file. It has configurable data width and register count and two write ports with fixed priority. Optional write-to-read bypass and an optional hardwired zero register are selected by parameter. After reset, a hardware sweep clears every register, so no register ever holds X. It sits in the decode/writeback path of the MIPS datapath.

## Interface
- WIDTH, 32, data width of each register in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, 1: register 0 reads 0 and ignores writes; 0: register 0 is an ordinary register
- BYPASS, 1, 1: reads forward same-cycle write data; 0: reads show stored contents only

Ports:
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset
- D_En  input  1  write enable, port D (high priority)
- D_Addr  input  ADDR_W  write address, port D
- D_in  input  WIDTH  write data, port D
- E_En  input  1  write enable, port E (low priority)
- E_Addr  input  ADDR_W  write address, port E
- E_in  input  WIDTH  write data, port E
- S_Addr  input  ADDR_W  read address, port S
- T_Addr  input  ADDR_W  read address, port T
- S  output  WIDTH  read data, port S (combinational)
- T  output  WIDTH  read data, port T (combinational)
- ready  output  1  high once the clear sweep is complete and the file accepts writes

## Operation
- Two-state FSM: INIT and RUN. Sweep counter clr_idx is ADDR_W+1 bits wide.
- reset low (async): state=INIT, clr_idx=0, ready=0. Register contents are not touched by async reset.
- INIT: each rising edge writes 0 to reg[clr_idx] and increments clr_idx. The edge that clears reg[DEPTH-1] moves the FSM to RUN and sets ready=1.
- INIT: D_En and E_En are ignored. S and T are forced to 0.
- RUN: a write with D_En=1 stores D_in into reg[D_Addr]. A write with E_En=1 stores E_in into reg[E_Addr].
- Both ports enabled with D_Addr==E_Addr: port D wins and the E write is dropped entirely.
- ZERO_REG=1: writes to address 0 are dropped on either port, and reads of address 0 return 0 in both states.
- Read data in RUN with BYPASS=1: if the read address matches an active, non-dropped write, output that write's data (D before E). Otherwise output the stored value.
- Read data in RUN with BYPASS=0: always the stored value.
- Dropped writes (to address 0 under ZERO_REG, or port E on conflict) are never forwarded.
- RUN is permanent until reset goes low again. Reset asserted during INIT restarts the sweep from register 0.

## Timing
- Reset values: ready=0, S=0, T=0, state=INIT, clr_idx=0.
- The sweep takes exactly DEPTH rising edges after reset deasserts. ready rises after edge DEPTH (32 edges for defaults).
- Write latency: 1 clock. Data is stored on the edge where En is sampled high.
- Read latency: 0. S and T are combinational from addresses and storage, plus write inputs when BYPASS=1.
- BYPASS=0: the written value is visible on S/T in the cycle after the write edge.
- ready is registered and has no combinational path from inputs.
- Writes presented in the same cycle ready first goes high are accepted.
- No unknown values appear on S or T after the sweep for any address.

## Test plan
- Power-up sweep: hold reset low 3 cycles, then release and read all 32 addresses -> ready=0 for the first 31 edges and 1 after edge 32. Every register reads 32'h0. D_En=1 pulses during INIT leave all registers at 0.
- Basic write/read: D_En=1, D_Addr=5, D_in=32'hDEADBEEF, then S_Addr=5 -> S=32'hDEADBEEF one cycle later. A write to address 0 -> S_Addr=0 reads 0 when ZERO_REG=1.
- Dual-write conflict: D_Addr=E_Addr=9, D_in=32'h11111111, E_in=32'h22222222 -> reg 9 = 32'h11111111. Distinct addresses 3 and 4 -> both written in the same cycle.
- Bypass: BYPASS=1, D_En=1, D_Addr=7, D_in=32'hA5A5A5A5, T_Addr=7 in the same cycle -> T=32'hA5A5A5A5 before the edge. With BYPASS=0 -> T shows the old value until after the edge.
- Mid-sweep reset: pull reset low at sweep edge 10, then release -> ready stays 0 for a full 32 further edges, and all registers read 0.
- Parameter sweep: WIDTH=16, ADDR_W=3, ZERO_REG=0 -> ready after 8 edges. A write to address 0 of 16'h1234 reads back 16'h1234.
